// File: rtl/edge_event_collector_pkg.sv
// Shared types for the edge event collector and the detector pipeline it follows.
// Row/column index widths are fixed here so both sides agree on the event format.
package edge_event_collector_pkg;

    localparam int PipelineHeight = 5;
    localparam int ColumnWidth    = 8;
    localparam int RowWidth       = $clog2(PipelineHeight);

    typedef logic [RowWidth-1:0]    RowIndex;
    typedef logic [ColumnWidth-1:0] ColumnIndex;

    typedef struct packed {
        RowIndex    row;
        ColumnIndex column;
    } EventRecord;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/edge_event_collector_fifo.sv
// Show-ahead FIFO of event records. When empty, the output holds the last popped
// record so the head fields do not jump to stale storage.
module event_fifo
    import edge_event_collector_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_push,
    input  EventRecord i_data,
    input  logic       i_pop,
    output EventRecord o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW   = $clog2(Depth);
    localparam int CntW = AW + 1;

    EventRecord          r_mem [Depth];
    EventRecord          r_last;
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [CntW-1:0]     r_cnt;
    logic                w_push;
    logic                w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CntW'(Depth));
    assign w_pop   = i_pop & ~o_empty;
    // A pop frees the head slot in the same edge, so full+pop may still accept a push.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? r_last : r_mem[r_rd];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_last <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_last <= r_mem[r_rd];
                r_rd   <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/edge_event_collector.sv
// Debounces per-row detector hits, records the first-hit column of each edge and
// queues {row, column} events through a show-ahead FIFO with drop accounting.
module edge_event_collector
    import edge_event_collector_pkg::*;
#(
    parameter int RunLength = 3,
    parameter int FifoDepth = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      detect_valid,
    input  logic [PipelineHeight-1:0] detect,
    input  ColumnIndex                column,
    output logic                      event_valid,
    input  logic                      event_ready,
    output RowIndex                   event_row,
    output ColumnIndex                event_column,
    output logic                      overflow,
    output logic [7:0]                dropped_count,
    input  logic                      clear_overflow
);
    localparam logic [3:0] RunMax  = 4'(RunLength);
    localparam logic [3:0] RunFire = 4'(RunLength - 1);

    logic [3:0]                r_cnt       [PipelineHeight];
    ColumnIndex                r_first_col [PipelineHeight];
    ColumnIndex                r_pend_col  [PipelineHeight];
    logic [PipelineHeight-1:0] r_pend;
    logic                      r_overflow;
    logic [7:0]                r_dropped;

    logic [PipelineHeight-1:0] w_trig;
    logic [PipelineHeight-1:0] w_drop;
    logic [PipelineHeight-1:0] w_drain_vec;
    logic [7:0]                w_drop_cnt;
    logic                      w_any;
    RowIndex                   w_sel;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    EventRecord                w_head;
    EventRecord                w_push_rec;

    // Lowest pending row wins the single push slot per cycle.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = PipelineHeight - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_any = 1'b1;
                w_sel = RowIndex'(i);
            end
        end
    end

    assign w_pop      = event_valid & event_ready;
    assign w_push     = w_any & (~w_full | w_pop);
    assign w_push_rec = '{row: w_sel, column: r_pend_col[w_sel]};

    always_comb begin
        w_drain_vec = '0;
        if (w_push) w_drain_vec[w_sel] = 1'b1;
    end

    // A row draining this cycle has room for a fresh trigger; only a still-held entry drops.
    always_comb begin
        w_trig     = '0;
        w_drop     = '0;
        w_drop_cnt = '0;
        for (int i = 0; i < PipelineHeight; i++) begin
            w_trig[i]  = detect_valid & detect[i] & (r_cnt[i] == RunFire);
            w_drop[i]  = w_trig[i] & r_pend[i] & ~w_drain_vec[i];
            w_drop_cnt = w_drop_cnt + {7'd0, w_drop[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PipelineHeight; i++) begin
                r_cnt[i]       <= '0;
                r_first_col[i] <= '0;
                r_pend_col[i]  <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < PipelineHeight; i++) begin
                if (detect_valid) begin
                    if (detect[i]) begin
                        if (r_cnt[i] == '0) r_first_col[i] <= column;
                        if (r_cnt[i] != RunMax) r_cnt[i] <= r_cnt[i] + 4'd1;
                    end else begin
                        r_cnt[i] <= '0;
                    end
                end
                if (w_trig[i] && !w_drop[i]) begin
                    r_pend[i]     <= 1'b1;
                    r_pend_col[i] <= (RunLength == 1) ? column : r_first_col[i];
                end else if (w_drain_vec[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (|w_drop) begin
            r_overflow <= 1'b1;
            r_dropped  <= sat_add8(clear_overflow ? 8'd0 : r_dropped, w_drop_cnt);
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end
    end

    event_fifo #(.Depth(FifoDepth)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign event_valid   = ~w_empty;
    assign event_row     = w_head.row;
    assign event_column  = w_head.column;
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;

endmodule

// File: tb/tb_edge_event_collector.sv
// Directed scenarios plus a random phase, checked each cycle against a queue-based
// reference model of the event collector.
module tb_edge_event_collector;
    import edge_event_collector_pkg::*;

    localparam int RL = 3;
    localparam int FD = 8;
    localparam int PH = PipelineHeight;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          detect_valid;
    logic [PH-1:0] detect;
    ColumnIndex    column;
    logic          event_valid;
    logic          event_ready;
    RowIndex       event_row;
    ColumnIndex    event_column;
    logic          overflow;
    logic [7:0]    dropped_count;
    logic          clear_overflow;

    always #5 clock = ~clock;

    edge_event_collector #(.RunLength(RL), .FifoDepth(FD)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .detect_valid   (detect_valid),
        .detect         (detect),
        .column         (column),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_row      (event_row),
        .event_column   (event_column),
        .overflow       (overflow),
        .dropped_count  (dropped_count),
        .clear_overflow (clear_overflow)
    );

    // Reference model state; events encoded as row*256 + column.
    int m_run   [PH];
    int m_first [PH];
    bit m_pend  [PH];
    int m_pcol  [PH];
    int m_q     [$];
    bit m_ovf;
    int m_drops;

    int errors = 0;
    int checks = 0;
    int log_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lg(input int k);
        return (k < log_q.size()) ? log_q[k] : -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < PH; i++) begin
            m_run[i] = 0; m_first[i] = 0; m_pend[i] = 0; m_pcol[i] = 0;
        end
        m_q.delete();
        m_ovf   = 0;
        m_drops = 0;
    endfunction

    function automatic void model_step();
        bit pop, push, trig;
        int sel, ev, ndrop, old_first;
        pop  = (m_q.size() > 0) && event_ready;
        sel  = -1;
        for (int i = 0; i < PH; i++) if (m_pend[i] && sel < 0) sel = i;
        push = (sel >= 0) && ((m_q.size() < FD) || pop);
        ev   = 0;
        if (push) begin
            ev = sel * 256 + m_pcol[sel];
            m_pend[sel] = 0;
        end
        ndrop = 0;
        for (int i = 0; i < PH; i++) begin
            trig      = detect_valid && detect[i] && (m_run[i] == RL - 1);
            old_first = m_first[i];
            if (detect_valid) begin
                if (detect[i]) begin
                    if (m_run[i] == 0) m_first[i] = int'(column);
                    if (m_run[i] < RL) m_run[i]++;
                end else begin
                    m_run[i] = 0;
                end
            end
            if (trig) begin
                if (m_pend[i]) ndrop++;
                else begin
                    m_pend[i] = 1;
                    m_pcol[i] = (RL == 1) ? int'(column) : old_first;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(ev);
        if (ndrop > 0) begin
            m_ovf   = 1;
            m_drops = (clear_overflow ? 0 : m_drops) + ndrop;
            if (m_drops > 255) m_drops = 255;
        end else if (clear_overflow) begin
            m_ovf   = 0;
            m_drops = 0;
        end
    endfunction

    task automatic check_outputs();
        chk("valid", event_valid, (m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("row", event_row, m_q[0] / 256);
            chk("column", event_column, m_q[0] % 256);
        end
        chk("overflow", overflow, m_ovf);
        chk("dropped", dropped_count, m_drops);
    endtask

    task automatic cyc(input bit dv, input logic [PH-1:0] det, input int col,
                       input bit rdy, input bit clr);
        detect_valid   = dv;
        detect         = det;
        column         = 8'(col);
        event_ready    = rdy;
        clear_overflow = clr;
        if (event_valid && event_ready)
            log_q.push_back(int'(event_row) * 256 + int'(event_column));
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    // Eight events from rows 0-3 fill the FIFO, row 4 stays pending, then re-triggers.
    task automatic fill_and_drop(input bit clr_last);
        for (int c = 30; c <= 32; c++) cyc(1, 5'b01111, c, 0, 0);
        cyc(1, 5'b00000, 33, 0, 0);
        for (int c = 34; c <= 36; c++) cyc(1, 5'b01111, c, 0, 0);
        repeat (6) cyc(1, 5'b00000, 37, 0, 0);
        for (int c = 40; c <= 42; c++) cyc(1, 5'b10000, c, 0, 0);
        cyc(1, 5'b00000, 43, 0, 0);
        cyc(1, 5'b10000, 44, 0, 0);
        cyc(1, 5'b10000, 45, 0, 0);
        cyc(1, 5'b10000, 46, 0, clr_last);
    endtask

    initial begin
        logic [PH-1:0] rdet;
        int rc;
        reset_n = 0; detect_valid = 0; detect = '0; column = '0;
        event_ready = 0; clear_overflow = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        chk("rst_row", event_row, 0);
        chk("rst_col", event_column, 0);
        reset_n = 1;

        // Single held row: one event at its first-hit column, visible two edges after the firing beat.
        log_q.delete();
        for (int c = 10; c <= 20; c++) begin
            cyc(1, 5'b00100, c, 1, 0);
            if (c == 12) chk("lat_e0", event_valid, 0);
            if (c == 13) chk("lat_e1", event_valid, 1);
        end
        repeat (3) cyc(1, 5'b00000, 21, 1, 0);
        chk("s1_n", log_q.size(), 1);
        chk("s1_e0", lg(0), 2 * 256 + 10);

        // Three rows firing together drain lowest-first.
        log_q.delete();
        for (int c = 18; c <= 20; c++) cyc(1, 5'b11001, c, 1, 0);
        repeat (5) cyc(1, 5'b00000, 21, 1, 0);
        chk("s2_n", log_q.size(), 3);
        chk("s2_e0", lg(0), 0 * 256 + 18);
        chk("s2_e1", lg(1), 3 * 256 + 18);
        chk("s2_e2", lg(2), 4 * 256 + 18);

        // Broken run is discarded; invalid beats do not break a run.
        log_q.delete();
        cyc(1, 5'b00010, 10, 1, 0);
        cyc(1, 5'b00010, 11, 1, 0);
        cyc(1, 5'b00000, 12, 1, 0);
        cyc(1, 5'b00010, 13, 1, 0);
        cyc(0, 5'b00000, 13, 1, 0);
        cyc(0, 5'b00000, 13, 1, 0);
        cyc(1, 5'b00010, 14, 1, 0);
        cyc(1, 5'b00010, 15, 1, 0);
        repeat (4) cyc(1, 5'b00000, 16, 1, 0);
        chk("s3_n", log_q.size(), 1);
        chk("s3_e0", lg(0), 1 * 256 + 13);

        // Full FIFO: pending row re-triggers and drops; drain keeps original column.
        fill_and_drop(0);
        chk("s4_ovf", overflow, 1);
        chk("s4_drop", dropped_count, 1);
        log_q.delete();
        repeat (12) cyc(1, 5'b00000, 47, 1, 0);
        chk("s4_n", log_q.size(), 9);
        for (int k = 0; k < 8; k++)
            chk($sformatf("s4_e%0d", k), lg(k), (k % 4) * 256 + ((k < 4) ? 30 : 34));
        chk("s4_e8", lg(8), 4 * 256 + 40);

        // Drop with clear in the same cycle: the drop wins and counting restarts at one.
        fill_and_drop(1);
        chk("s5_ovf", overflow, 1);
        chk("s5_drop", dropped_count, 1);
        cyc(1, 5'b00000, 47, 0, 0);
        for (int c = 48; c <= 50; c++) cyc(1, 5'b10000, c, 0, 0);
        chk("s5_drop2", dropped_count, 2);
        cyc(1, 5'b00000, 51, 0, 1);
        chk("s5_clr_ovf", overflow, 0);
        chk("s5_clr_drop", dropped_count, 0);
        repeat (12) cyc(1, 5'b00000, 52, 1, 0);

        // Reset mid-operation with queued events, pending rows and partial runs.
        for (int c = 50; c <= 52; c++) cyc(1, 5'b11111, c, 0, 0);
        cyc(1, 5'b00000, 53, 0, 0);
        cyc(1, 5'b00000, 54, 0, 0);
        cyc(1, 5'b00011, 55, 0, 0);
        chk("s6_pre", event_valid, 1);
        detect_valid = 0;
        reset_n = 0;
        #1;
        chk("s6_async_valid", event_valid, 0);
        chk("s6_async_ovf", overflow, 0);
        chk("s6_async_row", event_row, 0);
        chk("s6_async_col", event_column, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
        log_q.delete();
        for (int c = 60; c <= 62; c++) begin
            cyc(1, 5'b00001, c, 1, 0);
            if (c == 61) chk("s6_no_early", event_valid, 0);
        end
        repeat (4) cyc(1, 5'b00000, 63, 1, 0);
        chk("s6_n", log_q.size(), 1);
        chk("s6_e0", lg(0), 0 * 256 + 60);

        // Random phase: held detect patterns, random valid/ready/clear.
        rdet = '0;
        rc   = 0;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) rdet = PH'($urandom & $urandom);
            cyc($urandom_range(0, 3) != 0, rdet, rc, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0);
            rc++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
